// File: rtl/bin_weight_mac_stream.sv
// Binary-weight (+1/-1) fully-connected engine: streams LANES-wide input beats, accumulates
// OUT_DIM dot products, saturates to BIT_CNT bits. Optional per-neuron bias under `BNW_BIAS_EN.
module bin_weight_mac_stream #(
  parameter int IN_DIM  = 64,
  parameter int OUT_DIM = 16,
  parameter int BIT_CNT = 8,
  parameter int LANES   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*BIT_CNT-1:0]   in_data,
  input  logic [OUT_DIM*LANES-1:0]   in_weight,
`ifdef BNW_BIAS_EN
  input  logic [OUT_DIM*BIT_CNT-1:0] in_bias,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_DIM*BIT_CNT-1:0] out_data
);

  localparam int ACC_W  = BIT_CNT + $clog2(IN_DIM) + 2;
  localparam int NBEATS = IN_DIM / LANES;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          beat_cnt;
  logic signed [ACC_W-1:0]   acc      [OUT_DIM];
  logic signed [ACC_W-1:0]   acc_nxt  [OUT_DIM];
  logic signed [ACC_W-1:0]   init_val [OUT_DIM];
  logic signed [ACC_W-1:0]   lane_ext [LANES];
  logic signed [ACC_W-1:0]   beat_sum_p0 [OUT_DIM];
  logic                      accept, last_beat, enter_done;

  function automatic logic signed [BIT_CNT-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] hi, lo;
    hi = {{(ACC_W-BIT_CNT+1){1'b0}}, {(BIT_CNT-1){1'b1}}};
    lo = {{(ACC_W-BIT_CNT+1){1'b1}}, {(BIT_CNT-1){1'b0}}};
    if (a > hi)      sat = hi[BIT_CNT-1:0];
    else if (a < lo) sat = lo[BIT_CNT-1:0];
    else             sat = a[BIT_CNT-1:0];
  endfunction

  // Lanes are widened before negation so that -(-2^(B-1)) stays exact.
  always_comb begin
    for (int k = 0; k < LANES; k++)
      lane_ext[k] = ACC_W'($signed(in_data[k*BIT_CNT +: BIT_CNT]));
  end

  always_comb begin
    for (int o = 0; o < OUT_DIM; o++) begin
      beat_sum_p0[o] = '0;
      for (int k = 0; k < LANES; k++) begin
        if (in_weight[o*LANES+k]) beat_sum_p0[o] = beat_sum_p0[o] + lane_ext[k];
        else                      beat_sum_p0[o] = beat_sum_p0[o] - lane_ext[k];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < OUT_DIM; o++) begin
`ifdef BNW_BIAS_EN
      init_val[o] = ACC_W'($signed(in_bias[o*BIT_CNT +: BIT_CNT]));
`else
      init_val[o] = '0;
`endif
      acc_nxt[o] = ((state == IDLE) ? init_val[o] : acc[o]) + beat_sum_p0[o];
    end
  end

  assign accept     = in_valid & in_ready & ~clear;
  assign last_beat  = ((state == IDLE) && (NBEATS == 1)) ||
                      ((state == ACC) && (beat_cnt == CNT_W'(NBEATS - 1)));
  assign enter_done = accept & last_beat;

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = (NBEATS == 1) ? DONE : ACC;
        ACC:     if (in_valid && last_beat) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != DONE);
    out_valid = (state == DONE);
  end

  // Accumulate stage: acc/out_data update on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      out_data <= '0;
      for (int o = 0; o < OUT_DIM; o++) acc[o] <= '0;
    end else begin
      state <= state_nxt;
      if (clear)
        beat_cnt <= '0;
      else if (accept)
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      if (accept)
        for (int o = 0; o < OUT_DIM; o++) acc[o] <= acc_nxt[o];
      if (enter_done)
        for (int o = 0; o < OUT_DIM; o++) out_data[o*BIT_CNT +: BIT_CNT] <= sat(acc_nxt[o]);
    end
  end

endmodule

// File: doc/bin_weight_mac_stream.md
# bin_weight_mac_stream

Sequential, parametrised binary-weight fully-connected engine. Accepts a signed fixed-point input vector as a stream of `LANES`-wide beats, with the matching ±1 weight slice on each beat. Accumulates `OUT_DIM` dot products in wide registers, then saturates each result to `BIT_CNT` bits and holds the output vector behind a valid/ready handshake. Sits between the activation buffer and the next layer's input stage of the BinaryNet hardware path.

## Interface
- `IN_DIM`, 64, input vector length; must be a multiple of `LANES`.
- `OUT_DIM`, 16, number of output neurons.
- `BIT_CNT`, 8, two's-complement width of input and output elements.
- `LANES`, 4, input elements per beat; `NBEATS = IN_DIM/LANES`.
- `ACC_W`, `BIT_CNT+$clog2(IN_DIM)+2`, accumulator width (derived; not overridden).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous abort; discards the partial vector and returns to IDLE.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_data`  in  `LANES*BIT_CNT`  signed elements; lane k at `[k*BIT_CNT +: BIT_CNT]`.
- `in_weight`  in  `OUT_DIM*LANES`  bit `[o*LANES+k]`: 1 = +1, 0 = −1.
- `in_bias`  in  `OUT_DIM*BIT_CNT`  signed per-output bias (sampled on first beat; present only with `BNW_BIAS_EN`).
- `out_valid`  out  1  result vector valid.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `out_data`  out  `OUT_DIM*BIT_CNT`  saturated signed results; neuron o at `[o*BIT_CNT +: BIT_CNT]`.

## Operation
- Three states: IDLE, ACC, DONE. Beat counter `beat_cnt`, width `$clog2(NBEATS)` (min 1).
- IDLE: `in_ready=1`. On an accepted beat: `acc[o] = init + Σk (w ? x : −x)`, where `init` = bias (sign-extended) with `BNW_BIAS_EN`, otherwise 0. `beat_cnt=1`. Next state is DONE if `NBEATS==1`, otherwise ACC.
- ACC: `in_ready=1`. On an accepted beat: `acc[o] += Σk (w ? x : −x)`. After beat `NBEATS−1`, go to DONE and reset `beat_cnt` to 0. Without `in_valid`, hold state.
- DONE: `in_ready=0`, `out_valid=1`. `out_data` is registered from saturated `acc` on entry and stays stable until the handshake completes. On `out_ready`, go to IDLE.
- Arithmetic:
  - Inputs are sign-extended to `ACC_W` before negation, so −(−2^(B−1)) = +2^(B−1) is exact.
  - No intermediate overflow is possible.
- Saturation:
  - `acc > 2^(B−1)−1` → `2^(B−1)−1`.
  - `acc < −2^(B−1)` → `−2^(B−1)`.
  - Otherwise the low `BIT_CNT` bits.
- `clear` has priority over all handshakes in every state. It returns to IDLE, zeros `beat_cnt`, and deasserts `out_valid`. An undelivered result is dropped.
- Beats presented while `in_ready=0` are ignored; the source must hold them.

## Timing
- Reset values:
  - state = IDLE, `beat_cnt=0`, `acc=0`.
  - `out_valid=0`, `out_data=0`, `in_ready=1` (combinational from state).
- Latency: last beat accepted at edge N → `out_valid=1` after edge N, i.e. visible in cycle N+1.
- `in_ready` is a function of state only. It has no combinational path from `out_ready`.
- Minimum vector period is `NBEATS+1` cycles: the DONE cycle blocks input, and a new first beat can be accepted in the cycle after the output handshake.
- `rst` asserted mid-vector or in DONE asynchronously forces all reset values. The next vector starts clean.
- `clear` and `in_valid` asserted in the same cycle: the beat is not accumulated, and `in_ready` still reads 1 (beat is dropped).

## Configuration
- `BNW_BIAS_EN` defined:
  - `in_bias` port exists.
  - Accumulators initialise to the bias sampled on the first accepted beat.
- `BNW_BIAS_EN` undefined:
  - Port is absent.
  - Accumulators initialise to 0.
  - No bias registers are built.

## Test plan
Bench config: `BIT_CNT=8`, `IN_DIM=4`, `LANES=2`, `OUT_DIM=2`.
- Beats {10,20},{30,40}; out0 weights all 1, out1 weights all 0 → out0=100, out1=−100. `out_valid` rises one cycle after the second beat.
- Saturation:
  - All inputs 127, weights 1 → 127 (508 clamped).
  - All inputs −128, weights 1 → −128.
  - All inputs −128, weights 0 → 127.
- Backpressure: hold `out_ready=0` for 5 cycles and drive `in_valid=1` with new data throughout → `out_data` stable, `in_ready=0`, no beat consumed. After `out_ready`, the next vector computes correctly.
- Reset mid-vector: assert `rst` after the first beat, release it, then send {1,1},{1,1} with weights 1 → out0=4 (no residue).
- `clear` in DONE before `out_ready` → `out_valid` drops the next cycle and IDLE accepts a new vector.
- With `BNW_BIAS_EN`: bias {−5, 3}, inputs {1,2},{3,4}, weights all 1 → {5, 13}. Bias 127 + sum 100 → 127.
